// File: rtl/gcd_pkg.sv
// Shared definitions for the GCD engine: FSM state encoding, algorithm
// selection constants and a helper for sizing the power-of-two shift count.
package gcd_pkg;

    // Engine control states; encoding is fixed so software/debug views agree
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } gcd_state_e;

    // Algorithm select values carried on the mode input
    localparam logic MODE_SUB = 1'b0;
    localparam logic MODE_BIN = 1'b1;

    // Width of the common power-of-two counter used by the binary algorithm.
    // One bit more than clog2 so that a count of WIDTH-1 always fits.
    function automatic int shiftCountWidth(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/gcd_step.sv
// One reduction step of either GCD algorithm, purely combinational.
// Given the current operand pair, the accumulated common-factor shift and
// the mode, it reports whether the pair is terminal (and what the result is)
// and, if not, the operands and shift count after one more step.
module gcd_step
    import gcd_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int KW    = shiftCountWidth(WIDTH)
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [KW-1:0]    k_i,
    input  logic             mode_i,
    output logic [WIDTH-1:0] a_o,
    output logic [WIDTH-1:0] b_o,
    output logic [KW-1:0]    k_o,
    output logic             terminal_o,
    output logic             bothZero_o,
    output logic [WIDTH-1:0] result_o
);

    localparam logic [KW-1:0] MAX_SHIFT = KW'(WIDTH - 1);

    logic             aIsZero;
    logic             bIsZero;
    logic             aGtB;
    logic [WIDTH-1:0] aMinusB;
    logic [WIDTH-1:0] bMinusA;
    logic [KW-1:0]    shiftAmt;

    // Shared comparisons and differences; the subtraction that is actually
    // used is always larger-minus-smaller, so neither difference underflows
    // where it matters
    always_comb begin
        aIsZero = (a_i == '0);
        bIsZero = (b_i == '0);
        aGtB    = (a_i > b_i);
        aMinusB = a_i - b_i;
        bMinusA = b_i - a_i;
    end

    // Terminal detection and final result; the shift is clamped so the
    // restored common factor can never push bits beyond the operand width
    always_comb begin
        terminal_o = (a_i == b_i) | aIsZero | bIsZero;
        bothZero_o = aIsZero & bIsZero;
        shiftAmt   = (k_i > MAX_SHIFT) ? MAX_SHIFT : k_i;
        result_o   = (a_i | b_i) << shiftAmt;
    end

    // Next operand pair for one non-terminal step; binary mode applies only
    // the first matching rule so exactly one action happens per cycle
    always_comb begin
        a_o = a_i;
        b_o = b_i;
        k_o = k_i;
        if (mode_i == MODE_SUB) begin
            if (aGtB) begin
                a_o = aMinusB;
            end else begin
                b_o = bMinusA;
            end
        end else begin
            if (!a_i[0] && !b_i[0]) begin
                a_o = a_i >> 1;
                b_o = b_i >> 1;
                k_o = k_i + KW'(1);
            end else if (!a_i[0]) begin
                a_o = a_i >> 1;
            end else if (!b_i[0]) begin
                b_o = b_i >> 1;
            end else if (aGtB) begin
                a_o = aMinusB;
            end else begin
                b_o = bMinusA;
            end
        end
    end

endmodule

// File: rtl/gcd_engine.sv
// Iterative GCD engine with a valid/ready operand port and a valid/ready
// result port. One operation is in flight at a time: operands are captured
// in IDLE, reduced one step per cycle in CALC, and the result is held in
// DONE until the consumer takes it.
module gcd_engine
    import gcd_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] gcd_out,
    output logic [CNT_W-1:0] iter_count,
    output logic             zero_flag
);

    localparam int KW = shiftCountWidth(WIDTH);

    gcd_state_e       state_q,  state_d;
    logic [WIDTH-1:0] opA_q,    opA_d;
    logic [WIDTH-1:0] opB_q,    opB_d;
    logic [KW-1:0]    k_q,      k_d;
    logic             mode_q,   mode_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [CNT_W-1:0] count_q,  count_d;
    logic             zero_q,   zero_d;

    logic             acceptIn;
    logic [WIDTH-1:0] stepA;
    logic [WIDTH-1:0] stepB;
    logic [KW-1:0]    stepK;
    logic             stepTerminal;
    logic             stepBothZero;
    logic [WIDTH-1:0] stepResult;

    gcd_step #(
        .WIDTH (WIDTH),
        .KW    (KW)
    ) u_step (
        .a_i        (opA_q),
        .b_i        (opB_q),
        .k_i        (k_q),
        .mode_i     (mode_q),
        .a_o        (stepA),
        .b_o        (stepB),
        .k_o        (stepK),
        .terminal_o (stepTerminal),
        .bothZero_o (stepBothZero),
        .result_o   (stepResult)
    );

    // Handshake outputs depend only on state and reset, never on the
    // opposite port's valid/ready, so no combinational path crosses the engine
    always_comb begin
        in_ready   = (state_q == IDLE) & ~rst;
        out_valid  = (state_q == DONE) & ~rst;
        acceptIn   = in_valid & in_ready;
        gcd_out    = result_q;
        iter_count = count_q;
        zero_flag  = zero_q;
    end

    // Next-state and datapath control: capture in IDLE, one step or the
    // terminal write-back per CALC cycle, wait for the consumer in DONE
    always_comb begin
        state_d  = state_q;
        opA_d    = opA_q;
        opB_d    = opB_q;
        k_d      = k_q;
        mode_d   = mode_q;
        result_d = result_q;
        count_d  = count_q;
        zero_d   = zero_q;
        case (state_q)
            IDLE: begin
                if (acceptIn) begin
                    opA_d   = a_in;
                    opB_d   = b_in;
                    mode_d  = mode;
                    k_d     = '0;
                    count_d = '0;
                    state_d = CALC;
                end
            end
            CALC: begin
                if (stepTerminal) begin
                    result_d = stepResult;
                    zero_d   = stepBothZero;
                    state_d  = DONE;
                end else begin
                    opA_d = stepA;
                    opB_d = stepB;
                    k_d   = stepK;
                    if (count_q != '1) begin
                        count_d = count_q + CNT_W'(1);
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any operation in progress
    // and clears every result register so nothing stale is presented
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            opA_q    <= '0;
            opB_q    <= '0;
            k_q      <= '0;
            mode_q   <= MODE_SUB;
            result_q <= '0;
            count_q  <= '0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            opA_q    <= opA_d;
            opB_q    <= opB_d;
            k_q      <= k_d;
            mode_q   <= mode_d;
            result_q <= result_d;
            count_q  <= count_d;
            zero_q   <= zero_d;
        end
    end

endmodule

// File: tb/tb_gcd_engine.sv
// Directed bench for gcd_engine: a table of operand pairs with hand-computed
// results, step counts and latencies, plus hand-written sequences for
// backpressure, ignored input during CALC and reset mid-operation. A second
// instance with a 4-bit counter shares all inputs to exercise saturation.
module tb_gcd_engine;

    typedef struct {
        logic       mode;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] expGcd;
        int         expCount;
        logic       expZero;
        int         expK;
        string      name;
    } vec_t;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a_in;
    logic [7:0] b_in;
    logic       mode;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] gcd_out;
    logic [7:0] iter_count;
    logic       zero_flag;

    logic       satInReady;
    logic       satOutValid;
    logic [7:0] satGcd;
    logic [3:0] satCount;
    logic       satZero;

    int compared;
    int mismatched;

    vec_t vecs[12];

    gcd_engine #(
        .WIDTH (8),
        .CNT_W (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a_in       (a_in),
        .b_in       (b_in),
        .mode       (mode),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .gcd_out    (gcd_out),
        .iter_count (iter_count),
        .zero_flag  (zero_flag)
    );

    gcd_engine #(
        .WIDTH (8),
        .CNT_W (4)
    ) satDut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (satInReady),
        .a_in       (a_in),
        .b_in       (b_in),
        .mode       (mode),
        .out_valid  (satOutValid),
        .out_ready  (out_ready),
        .gcd_out    (satGcd),
        .iter_count (satCount),
        .zero_flag  (satZero)
    );

    // Free-running clock, 10 time units per cycle
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point: counts every check and reports mismatches
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Launch one operation and wait (bounded) for the result; lat is the
    // cycle offset from the handshake cycle to the first out_valid cycle
    task automatic applyStimulus(input logic m, input logic [7:0] a, input logic [7:0] b,
                                 output int lat, output bit timedOut);
        @(negedge clk);
        mode     = m;
        a_in     = a;
        b_in     = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat      = 1;
        timedOut = 1'b1;
        for (int c = 0; c < 1000; c++) begin
            if (out_valid) begin
                timedOut = 1'b0;
                break;
            end
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    // Hand the result to the consumer for exactly one cycle
    task automatic releaseResult();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    // Main sequence: reset, vector table, then the multi-cycle corner cases
    initial begin
        int  lat;
        bit  timedOut;
        int  expSat;

        compared   = 0;
        mismatched = 0;
        rst        = 1'b1;
        in_valid   = 1'b0;
        out_ready  = 1'b0;
        a_in       = '0;
        b_in       = '0;
        mode       = 1'b0;

        vecs[0]  = '{1'b0, 8'd48,  8'd18, 8'd6,  4,   1'b0, 0, "sub48_18"};
        vecs[1]  = '{1'b1, 8'd48,  8'd18, 8'd6,  6,   1'b0, 1, "bin48_18"};
        vecs[2]  = '{1'b0, 8'd0,   8'd0,  8'd0,  0,   1'b1, 0, "sub0_0"};
        vecs[3]  = '{1'b1, 8'd0,   8'd0,  8'd0,  0,   1'b1, 0, "bin0_0"};
        vecs[4]  = '{1'b0, 8'd0,   8'd35, 8'd35, 0,   1'b0, 0, "sub0_35"};
        vecs[5]  = '{1'b0, 8'd255, 8'd1,  8'd1,  254, 1'b0, 0, "sub255_1"};
        vecs[6]  = '{1'b1, 8'd255, 8'd1,  8'd1,  14,  1'b0, 0, "bin255_1"};
        vecs[7]  = '{1'b0, 8'd21,  8'd14, 8'd7,  2,   1'b0, 0, "sub21_14"};
        vecs[8]  = '{1'b1, 8'd21,  8'd14, 8'd7,  3,   1'b0, 0, "bin21_14"};
        vecs[9]  = '{1'b0, 8'd35,  8'd0,  8'd35, 0,   1'b0, 0, "sub35_0"};
        vecs[10] = '{1'b1, 8'd64,  8'd16, 8'd16, 6,   1'b0, 4, "bin64_16"};
        vecs[11] = '{1'b0, 8'd7,   8'd5,  8'd1,  4,   1'b0, 0, "sub7_5"};

        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst.in_ready", 32'(in_ready), 32'd0);
        checkOutput("rst.out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst.gcd_out", 32'(gcd_out), 32'd0);
        checkOutput("rst.iter_count", 32'(iter_count), 32'd0);
        checkOutput("rst.zero_flag", 32'(zero_flag), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("rst.in_ready_after", 32'(in_ready), 32'd1);

        for (int i = 0; i < 12; i++) begin
            applyStimulus(vecs[i].mode, vecs[i].a, vecs[i].b, lat, timedOut);
            checkOutput({vecs[i].name, ".timeout"}, 32'(timedOut), 32'd0);
            expSat = (vecs[i].expCount > 15) ? 15 : vecs[i].expCount;
            checkOutput({vecs[i].name, ".gcd"}, 32'(gcd_out), 32'(vecs[i].expGcd));
            checkOutput({vecs[i].name, ".count"}, 32'(iter_count), 32'(vecs[i].expCount));
            checkOutput({vecs[i].name, ".zero"}, 32'(zero_flag), 32'(vecs[i].expZero));
            checkOutput({vecs[i].name, ".latency"}, 32'(lat), 32'(vecs[i].expCount + 2));
            checkOutput({vecs[i].name, ".k"}, 32'(dut.k_q), 32'(vecs[i].expK));
            checkOutput({vecs[i].name, ".satValid"}, 32'(satOutValid), 32'd1);
            checkOutput({vecs[i].name, ".satGcd"}, 32'(satGcd), 32'(vecs[i].expGcd));
            checkOutput({vecs[i].name, ".satCount"}, 32'(satCount), 32'(expSat));
            releaseResult();
            checkOutput({vecs[i].name, ".idle"}, 32'(in_ready), 32'd1);
            checkOutput({vecs[i].name, ".validDrop"}, 32'(out_valid), 32'd0);
        end

        // Backpressure with in_valid held high during CALC/DONE: the extra
        // operands must be ignored and the result must stay put
        @(negedge clk);
        mode     = 1'b0;
        a_in     = 8'd48;
        b_in     = 8'd18;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        a_in     = 8'd100;
        b_in     = 8'd75;
        timedOut = 1'b1;
        for (int c = 0; c < 100; c++) begin
            if (out_valid) begin
                timedOut = 1'b0;
                break;
            end
            checkOutput("bp.busy_in_ready", 32'(in_ready), 32'd0);
            @(posedge clk);
            #1;
        end
        checkOutput("bp.timeout", 32'(timedOut), 32'd0);
        in_valid = 1'b0;
        for (int c = 0; c < 5; c++) begin
            checkOutput("bp.gcd", 32'(gcd_out), 32'd6);
            checkOutput("bp.count", 32'(iter_count), 32'd4);
            checkOutput("bp.zero", 32'(zero_flag), 32'd0);
            checkOutput("bp.out_valid", 32'(out_valid), 32'd1);
            checkOutput("bp.in_ready", 32'(in_ready), 32'd0);
            @(posedge clk);
            #1;
        end
        releaseResult();
        checkOutput("bp.idle", 32'(in_ready), 32'd1);
        checkOutput("bp.validDrop", 32'(out_valid), 32'd0);
        checkOutput("bp.gcdKept", 32'(gcd_out), 32'd6);

        // Reset in the middle of a long subtractive run aborts it cleanly
        @(negedge clk);
        mode     = 1'b0;
        a_in     = 8'd200;
        b_in     = 8'd8;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("abort.midCalc", 32'(out_valid), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("abort.out_valid", 32'(out_valid), 32'd0);
        checkOutput("abort.in_ready_rst", 32'(in_ready), 32'd0);
        checkOutput("abort.gcd", 32'(gcd_out), 32'd0);
        checkOutput("abort.count", 32'(iter_count), 32'd0);
        checkOutput("abort.zero", 32'(zero_flag), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("abort.in_ready", 32'(in_ready), 32'd1);
        applyStimulus(1'b0, 8'd21, 8'd14, lat, timedOut);
        checkOutput("abort.newTimeout", 32'(timedOut), 32'd0);
        checkOutput("abort.newGcd", 32'(gcd_out), 32'd7);
        checkOutput("abort.newCount", 32'(iter_count), 32'd2);
        checkOutput("abort.newLatency", 32'(lat), 32'd4);
        releaseResult();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
